yutorina_if_prefetch: RTL and testbench



---
 rtl/yutorina_if_prefetch.sv | 126 ++++++++++++
 tb/tb_yutorina_if_prefetch.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/yutorina_if_prefetch.sv
// Instruction-fetch stage: sequential fetch over a req/rdy memory port into a
// DEPTH-entry {pc, insn} prefetch FIFO, with branch redirect and stale-response discard.
module yutorina_if_prefetch #(
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32,
  parameter int DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_addr,
  output logic              mem_req,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_rdy,
  output logic              busy,
  output logic [ADDR_W-1:0] if_pc,
  output logic [DATA_W-1:0] if_insn,
  output logic              if_valid
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic {FETCH, DISCARD} state_t;

  state_t            state;
  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] br_pc;
  logic [ADDR_W-1:0] fifo_pc [DEPTH];
  logic [DATA_W-1:0] fifo_insn [DEPTH];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;
  logic [CW-1:0]     count;
  logic [ADDR_W-1:0] hold_pc;
  logic [DATA_W-1:0] hold_insn;

  logic full;
  logic not_empty;
  logic push;
  logic pop;

  // Handshake: mem_req/mem_addr stay asserted and stable until the cycle mem_rdy=1;
  // that cycle completes the transfer (mem_rdy may arrive in the request cycle).
  assign full      = (count == CW'(DEPTH));
  assign not_empty = (count != '0);
  assign mem_req   = ~rst & ((state == DISCARD) | ~full);
  assign mem_addr  = fetch_pc;
  assign busy      = mem_req & ~mem_rdy;
  assign if_valid  = ~rst & not_empty;
  assign push      = ~rst & (state == FETCH) & mem_req & mem_rdy & ~br_taken;
  assign pop       = if_valid & ~stall & ~br_taken;

  // When the FIFO is empty the outputs keep showing the last head entry.
  always_comb begin
    if_pc   = '0;
    if_insn = '0;
    if (!rst) begin
      if_pc   = not_empty ? fifo_pc[rd_ptr]   : hold_pc;
      if_insn = not_empty ? fifo_insn[rd_ptr] : hold_insn;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]   <= fetch_pc;
      fifo_insn[wr_ptr] <= mem_rdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= FETCH;
      fetch_pc  <= RESET_PC;
      br_pc     <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      hold_pc   <= '0;
      hold_insn <= '0;
    end else begin
      if (not_empty) begin
        hold_pc   <= fifo_pc[rd_ptr];
        hold_insn <= fifo_insn[rd_ptr];
      end
      if (br_taken) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
        // A branch during DISCARD supersedes the saved target.
        if (state == DISCARD) begin
          if (mem_rdy) begin
            fetch_pc <= br_addr;
            state    <= FETCH;
          end else begin
            br_pc <= br_addr;
          end
        end else if (mem_req && !mem_rdy) begin
          br_pc <= br_addr;
          state <= DISCARD;
        end else begin
          fetch_pc <= br_addr;
        end
      end else if (state == DISCARD) begin
        if (mem_rdy) begin
          fetch_pc <= br_pc;
          state    <= FETCH;
        end
      end else begin
        if (push) begin
          wr_ptr   <= wr_ptr + PW'(1);
          fetch_pc <= fetch_pc + ADDR_W'(1);
        end
        if (pop) rd_ptr <= rd_ptr + PW'(1);
        case ({push, pop})
          2'b10:   count <= count + CW'(1);
          2'b01:   count <= count - CW'(1);
          default: count <= count;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_yutorina_if_prefetch.sv
// Bench for yutorina_if_prefetch: directed scenarios plus random traffic,
// compared cycle by cycle against a queue-based model of the fetch stage.
module tb_yutorina_if_prefetch;

  localparam int ADDR_W = 30;
  localparam int DATA_W = 32;
  localparam int DEPTH = 4;
  localparam logic [ADDR_W-1:0] RESET_PC = 30'h3FFFFFFE;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              stall = 1'b0;
  logic              br_taken = 1'b0;
  logic [ADDR_W-1:0] br_addr = '0;
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              mem_rdy = 1'b0;
  logic              busy;
  logic [ADDR_W-1:0] if_pc;
  logic [DATA_W-1:0] if_insn;
  logic              if_valid;

  yutorina_if_prefetch #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .RESET_PC(RESET_PC)
  ) dut (
    .clk(clk), .rst(rst), .stall(stall), .br_taken(br_taken), .br_addr(br_addr),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_rdy(mem_rdy),
    .busy(busy), .if_pc(if_pc), .if_insn(if_insn), .if_valid(if_valid)
  );

  // clock/reset block
  always #5 clk = ~clk;

  // reference model: FIFO contents as a queue of {pc, insn}
  logic [ADDR_W+DATA_W-1:0] exp_q[$];
  logic [ADDR_W+DATA_W-1:0] m_last = '0;
  logic [ADDR_W-1:0]        m_pc = RESET_PC;
  logic [ADDR_W-1:0]        m_br = '0;
  logic                     m_disc = 1'b0;

  // memory model
  int wait_cfg = 0;
  int wcnt = 0;

  int passed = 0;
  int total = 0;

  function automatic logic [DATA_W-1:0] word_of(input logic [ADDR_W-1:0] a);
    return {2'b00, a} ^ 32'hA5A50000;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // driver task: one clock cycle of stimulus, check and model update
  task automatic step(input logic s, input logic b, input logic [ADDR_W-1:0] ba, input logic r);
    logic exp_req;
    logic exp_valid;
    logic [ADDR_W+DATA_W-1:0] head;
    @(negedge clk);
    stall = s; br_taken = b; br_addr = ba; rst = r;
    mem_rdy = 1'b0; mem_rdata = $urandom;
    #1;
    if (!r && mem_req === 1'b1 && wcnt >= wait_cfg) begin
      mem_rdy = 1'b1;
      mem_rdata = word_of(mem_addr);
    end
    #1;
    exp_req = m_disc || (exp_q.size() < DEPTH);
    exp_valid = (exp_q.size() != 0);
    head = exp_valid ? exp_q[0] : m_last;
    if (r) begin
      chk("rst_mem_req", mem_req, 0);
      chk("rst_if_valid", if_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_if_pc", if_pc, 0);
      chk("rst_if_insn", if_insn, 0);
    end else begin
      chk("mem_req", mem_req, exp_req);
      if (exp_req) chk("mem_addr", mem_addr, m_pc);
      chk("busy", busy, exp_req && !mem_rdy);
      chk("if_valid", if_valid, exp_valid);
      chk("if_pc", if_pc, head[ADDR_W+DATA_W-1:DATA_W]);
      chk("if_insn", if_insn, head[DATA_W-1:0]);
    end
    if (r) begin
      exp_q.delete(); m_pc = RESET_PC; m_disc = 1'b0; m_last = '0;
    end else begin
      if (exp_valid) m_last = exp_q[0];
      if (b) begin
        exp_q.delete();
        if (m_disc) begin
          if (mem_rdy) begin m_pc = ba; m_disc = 1'b0; end
          else m_br = ba;
        end else if (exp_req && !mem_rdy) begin
          m_disc = 1'b1; m_br = ba;
        end else begin
          m_pc = ba;
        end
      end else if (m_disc) begin
        if (mem_rdy) begin m_pc = m_br; m_disc = 1'b0; end
      end else begin
        if (exp_valid && !s) void'(exp_q.pop_front());
        if (exp_req && mem_rdy) begin
          exp_q.push_back({m_pc, word_of(m_pc)});
          m_pc = m_pc + 1'b1;
        end
      end
    end
    if (r || mem_rdy) wcnt = 0;
    else if (mem_req === 1'b1) wcnt++;
    @(posedge clk);
  endtask

  // advance until the pending request has waited one cycle
  task automatic run_to_wait1(input string tag);
    for (int i = 0; i < 20 && wcnt != 1; i++) step(1'b0, 1'b0, '0, 1'b0);
    chk(tag, wcnt, 1);
  endtask

  initial begin
    // reset, then zero-wait streaming across the pc wrap
    step(1'b0, 1'b0, '0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, '0, 1'b0);

    // stall 10 cycles: FIFO fills and requests stop, then drain
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, '0, 1'b0);
    chk("full_count", exp_q.size(), DEPTH);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0, 1'b0);

    // 3-cycle wait memory, branch to 0x100 on the second wait cycle
    wait_cfg = 3;
    run_to_wait1("wait_hit_a");
    step(1'b0, 1'b1, 30'h100, 1'b0);
    chk("discard_entered", m_disc, 1);
    for (int i = 0; i < 12; i++) step(1'b0, 1'b0, '0, 1'b0);

    // branch coincident with mem_rdy while stalled
    wait_cfg = 0;
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b1, 30'h200, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, '0, 1'b0);

    // two branches during one pending wait: last one wins
    wait_cfg = 4;
    run_to_wait1("wait_hit_b");
    step(1'b0, 1'b1, 30'h40, 1'b0);
    step(1'b0, 1'b1, 30'h80, 1'b0);
    chk("last_branch_kept", m_br, 30'h80);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b0, '0, 1'b0);

    // fill 3 entries, reset mid-wait, restart at RESET_PC through the wrap
    wait_cfg = 0;
    step(1'b0, 1'b1, 30'h10, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, '0, 1'b0);
    wait_cfg = 5;
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    chk("three_entries", exp_q.size(), 3);
    step(1'b1, 1'b0, '0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b1);
    wait_cfg = 0;
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0, '0, 1'b0);

    // random traffic
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 15) == 0) wait_cfg = $urandom_range(0, 3);
      step($urandom_range(0, 9) < 3, $urandom_range(0, 19) == 0,
           ($urandom_range(0, 3) == 0) ? 30'h3FFFFFFF - ADDR_W'($urandom_range(0, 2)) : ADDR_W'($urandom),
           $urandom_range(0, 99) == 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
